// File: rtl/lcd_pkg.sv
// Shared constants, state encoding and DDRAM address helpers for the LCD responder.
package lcd_pkg;

  localparam int unsigned DDRAM_DEPTH = 80;
  localparam int unsigned LINE_LEN    = 40;
  localparam int unsigned ADDR_W      = 7;
  localparam int unsigned DATA_W      = 8;
  localparam int unsigned CNT_W       = 16;

  localparam logic [DATA_W-1:0] LCD_SPACE = 8'h20;

  // Instruction class masks; the highest set bit selects the instruction.
  localparam logic [DATA_W-1:0] INSTR_SET_DDRAM = 8'h80;
  localparam logic [DATA_W-1:0] INSTR_SET_CGRAM = 8'h40;
  localparam logic [DATA_W-1:0] INSTR_FUNC_SET  = 8'h20;
  localparam logic [DATA_W-1:0] INSTR_SHIFT     = 8'h10;
  localparam logic [DATA_W-1:0] INSTR_DISPLAY   = 8'h08;
  localparam logic [DATA_W-1:0] INSTR_ENTRY     = 8'h04;
  localparam logic [DATA_W-1:0] INSTR_HOME      = 8'h02;
  localparam logic [DATA_W-1:0] INSTR_CLEAR     = 8'h01;

  localparam int unsigned DISP_D_BIT   = 2;
  localparam int unsigned DISP_C_BIT   = 1;
  localparam int unsigned ENTRY_ID_BIT = 1;

  localparam logic [ADDR_W-1:0] LINE0_FIRST = 7'h00;
  localparam logic [ADDR_W-1:0] LINE0_LAST  = 7'h27;
  localparam logic [ADDR_W-1:0] LINE1_FIRST = 7'h40;
  localparam logic [ADDR_W-1:0] LINE1_LAST  = 7'h67;

  typedef enum logic [1:0] {
    ST_RESET_CLEAR = 2'd0,
    ST_IDLE        = 2'd1,
    ST_EXEC        = 2'd2,
    ST_CLEAR       = 2'd3
  } lcd_state_t;

  // An address is valid when its column lies inside a 40-character line.
  function automatic logic addr_valid(input logic [ADDR_W-1:0] addr);
    return addr[5:0] < 6'(LINE_LEN);
  endfunction

  // Line 1 follows line 0 in the linear DDRAM array.
  function automatic logic [ADDR_W-1:0] addr_to_index(input logic [ADDR_W-1:0] addr);
    return {1'b0, addr[5:0]} + (addr[6] ? ADDR_W'(LINE_LEN) : ADDR_W'(0));
  endfunction

  // Step the address counter, wrapping between the two lines.
  function automatic logic [ADDR_W-1:0] ac_step(input logic [ADDR_W-1:0] ac, input logic inc);
    if (inc) begin
      if (ac == LINE0_LAST) return LINE1_FIRST;
      if (ac == LINE1_LAST) return LINE0_FIRST;
      return ac + ADDR_W'(1);
    end
    if (ac == LINE1_FIRST) return LINE0_LAST;
    if (ac == LINE0_FIRST) return LINE1_LAST;
    return ac - ADDR_W'(1);
  endfunction

endpackage

// File: rtl/lcd_ddram.sv
// 80x8 display RAM: one write/read port plus a registered scan port (read-before-write).
module lcd_ddram
  import lcd_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] index,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata_c,
  input  logic [ADDR_W-1:0] scan_addr,
  output logic [DATA_W-1:0] scan_char
);

  logic [DATA_W-1:0] mem [DDRAM_DEPTH];
  logic              in_range;

  assign in_range = index < ADDR_W'(DDRAM_DEPTH);
  assign rdata_c  = in_range ? mem[index] : LCD_SPACE;

  // Storage write; contents are initialised by the owner's clear sequence.
  always_ff @(posedge clock) begin
    if (we && in_range) mem[index] <= wdata;
  end

  // Scan read samples the pre-write contents; invalid addresses read as a space.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      scan_char <= '0;
    end else if (addr_valid(scan_addr)) begin
      scan_char <= mem[addr_to_index(scan_addr)];
    end else begin
      scan_char <= LCD_SPACE;
    end
  end

endmodule

// File: rtl/lcd_responder.sv
// Display-side HD44780-style bus responder: decodes strobes into DDRAM, AC and display state.
module lcd_responder
  import lcd_pkg::*;
#(
  parameter int unsigned CMD_CYCLES   = 2,
  parameter int unsigned CLEAR_CYCLES = 96
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              rs,
  input  logic              rw,
  input  logic [DATA_W-1:0] lcd_data_in,
  output logic [DATA_W-1:0] lcd_data_out,
  output logic              lcd_data_oe,
  output logic              busy,
  output logic [ADDR_W-1:0] address_counter,
  output logic              on,
  output logic              cursor_on,
  input  logic [ADDR_W-1:0] scan_addr,
  output logic [DATA_W-1:0] scan_char,
  output logic              cmd_ignored
);

  localparam int unsigned CLEAR_LEN = (CLEAR_CYCLES > DDRAM_DEPTH) ? CLEAR_CYCLES : DDRAM_DEPTH;
  localparam int unsigned CMD_LOAD  = (CMD_CYCLES > 0) ? CMD_CYCLES - 1 : 0;

  lcd_state_t        state;
  logic [CNT_W-1:0]  cnt;
  logic              enable_q;
  logic              inc_mode;
  logic              strobe;
  logic              clearing;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_index;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata_c;

  assign strobe   = enable_q & ~enable;
  assign clearing = (state == ST_RESET_CLEAR) || (state == ST_CLEAR);

  // RAM port steering: the clear sequence owns the port, otherwise accepted data writes at AC.
  always_comb begin
    mem_we    = 1'b0;
    mem_index = addr_to_index(address_counter);
    mem_wdata = lcd_data_in;
    if (clearing) begin
      if (cnt < CNT_W'(DDRAM_DEPTH)) begin
        mem_we    = 1'b1;
        mem_index = cnt[ADDR_W-1:0];
        mem_wdata = LCD_SPACE;
      end
    end else if (state == ST_IDLE && strobe && rs && !rw) begin
      mem_we = 1'b1;
    end
  end

  lcd_ddram u_ddram (
    .clock     (clock),
    .reset_n   (reset_n),
    .we        (mem_we),
    .index     (mem_index),
    .wdata     (mem_wdata),
    .rdata_c   (mem_rdata_c),
    .scan_addr (scan_addr),
    .scan_char (scan_char)
  );

  // Bus decode, busy sequencing and register updates.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state           <= ST_RESET_CLEAR;
      cnt             <= '0;
      enable_q        <= 1'b0;
      inc_mode        <= 1'b1;
      lcd_data_out    <= '0;
      lcd_data_oe     <= 1'b0;
      busy            <= 1'b1;
      address_counter <= '0;
      on              <= 1'b0;
      cursor_on       <= 1'b0;
      cmd_ignored     <= 1'b0;
    end else begin
      enable_q    <= enable;
      lcd_data_oe <= enable & rw;
      cmd_ignored <= 1'b0;

      // Keep read data on the bus ahead of the falling edge.
      if (enable && rw) begin
        lcd_data_out <= rs ? mem_rdata_c : {busy, address_counter};
      end

      case (state)
        ST_RESET_CLEAR, ST_CLEAR: begin
          if (cnt == CNT_W'(CLEAR_LEN - 1)) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_EXEC: begin
          if (cnt == '0) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: ;
      endcase

      if (strobe) begin
        if (!rs && rw) begin
          lcd_data_out <= {busy, address_counter};
        end else if (state != ST_IDLE) begin
          cmd_ignored <= 1'b1;
        end else if (rs) begin
          if (rw) lcd_data_out <= mem_rdata_c;
          address_counter <= ac_step(address_counter, inc_mode);
          state           <= ST_EXEC;
          busy            <= 1'b1;
          cnt             <= CNT_W'(CMD_LOAD);
        end else if (|(lcd_data_in & INSTR_SET_DDRAM)) begin
          if (addr_valid(lcd_data_in[ADDR_W-1:0])) begin
            address_counter <= lcd_data_in[ADDR_W-1:0];
            state           <= ST_EXEC;
            busy            <= 1'b1;
            cnt             <= CNT_W'(CMD_LOAD);
          end else begin
            cmd_ignored <= 1'b1;
          end
        end else if (|(lcd_data_in & INSTR_SET_CGRAM)) begin
          cmd_ignored <= 1'b1;
        end else if (|(lcd_data_in & (INSTR_FUNC_SET | INSTR_SHIFT | INSTR_DISPLAY |
                                      INSTR_ENTRY | INSTR_HOME))) begin
          if (|(lcd_data_in & (INSTR_FUNC_SET | INSTR_SHIFT))) begin
            // Accepted for bus compatibility; no visible effect.
          end else if (|(lcd_data_in & INSTR_DISPLAY)) begin
            on        <= lcd_data_in[DISP_D_BIT];
            cursor_on <= lcd_data_in[DISP_C_BIT];
          end else if (|(lcd_data_in & INSTR_ENTRY)) begin
            inc_mode <= lcd_data_in[ENTRY_ID_BIT];
          end else begin
            address_counter <= LINE0_FIRST;
          end
          state <= ST_EXEC;
          busy  <= 1'b1;
          cnt   <= CNT_W'(CMD_LOAD);
        end else if (|(lcd_data_in & INSTR_CLEAR)) begin
          address_counter <= LINE0_FIRST;
          inc_mode        <= 1'b1;
          state           <= ST_CLEAR;
          busy            <= 1'b1;
          cnt             <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_lcd_responder.sv
// Randomized self-checking bench for lcd_responder against a line/column reference model.
module tb_lcd_responder;

  localparam int CMD_CYCLES   = 2;
  localparam int CLEAR_CYCLES = 96;
  localparam int CLEAR_LEN    = (CLEAR_CYCLES > 80) ? CLEAR_CYCLES : 80;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic       rs = 1'b0;
  logic       rw = 1'b0;
  logic [7:0] lcd_data_in = 8'h00;
  logic [7:0] lcd_data_out;
  logic       lcd_data_oe;
  logic       busy;
  logic [6:0] address_counter;
  logic       on;
  logic       cursor_on;
  logic [6:0] scan_addr = 7'h00;
  logic [7:0] scan_char;
  logic       cmd_ignored;

  lcd_responder #(.CMD_CYCLES(CMD_CYCLES), .CLEAR_CYCLES(CLEAR_CYCLES)) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .enable          (enable),
    .rs              (rs),
    .rw              (rw),
    .lcd_data_in     (lcd_data_in),
    .lcd_data_out    (lcd_data_out),
    .lcd_data_oe     (lcd_data_oe),
    .busy            (busy),
    .address_counter (address_counter),
    .on              (on),
    .cursor_on       (cursor_on),
    .scan_addr       (scan_addr),
    .scan_char       (scan_char),
    .cmd_ignored     (cmd_ignored)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: linear character index 0..79, line 1 starting at index 40.
  logic [7:0] m_mem [80];
  int         m_idx;
  bit         m_inc;
  bit         m_on;
  bit         m_cur;
  int         m_busy_end;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] idx2addr(input int i);
    return (i < 40) ? 7'(i) : 7'(64 + i - 40);
  endfunction

  function automatic logic [7:0] scan_model(input logic [6:0] a);
    int col, line;
    col  = int'(a) % 64;
    line = int'(a) / 64;
    if (col >= 40) return 8'h20;
    return m_mem[line * 40 + col];
  endfunction

  function automatic bit busy_at(input int c);
    return c <= m_busy_end;
  endfunction

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic do_reset();
    enable  = 1'b0;
    reset_n = 1'b0;
    repeat (2) tick();
    check_eq("rst_data_out", lcd_data_out, 8'h00);
    check_eq("rst_oe", lcd_data_oe, 1'b0);
    check_eq("rst_busy", busy, 1'b1);
    check_eq("rst_ac", address_counter, 7'h00);
    check_eq("rst_on", on, 1'b0);
    check_eq("rst_cursor", cursor_on, 1'b0);
    check_eq("rst_scan", scan_char, 8'h00);
    check_eq("rst_ignored", cmd_ignored, 1'b0);
    reset_n = 1'b1;
    for (int i = 0; i < 80; i++) m_mem[i] = 8'h20;
    m_idx      = 0;
    m_inc      = 1'b1;
    m_on       = 1'b0;
    m_cur      = 1'b0;
    m_busy_end = cyc + CLEAR_LEN - 1;
  endtask

  // Wait (bounded) for busy to fall and confirm the cycle it fell on.
  task automatic wait_idle();
    int exp_c;
    int n;
    exp_c = (cyc > m_busy_end) ? cyc : m_busy_end + 1;
    n = 0;
    while (busy && n < 400) begin
      tick();
      n++;
    end
    check_eq("idle_cycle", cyc, exp_c);
  endtask

  // One bus transfer: E high for a cycle, then low; strobe is the cycle E drops.
  task automatic xfer(input logic r_s, input logic r_w, input logic [7:0] d);
    int         t;
    int         hb;
    bit         exp_ign;
    bit         has_out;
    logic [7:0] exp_out;
    logic [6:0] a;
    enable = 1'b1;
    rs = r_s;
    rw = r_w;
    lcd_data_in = d;
    tick();
    check_eq("oe_pre", lcd_data_oe, r_w);
    if (r_w && !r_s)
      check_eq("status_prefetch", lcd_data_out, {busy_at(cyc - 1), idx2addr(m_idx)});
    else if (r_w && !busy_at(cyc - 1))
      check_eq("data_prefetch", lcd_data_out, m_mem[m_idx]);
    enable = 1'b0;
    t = cyc;
    exp_ign = 1'b0;
    has_out = 1'b0;
    exp_out = 8'h00;
    if (!r_s && r_w) begin
      has_out = 1'b1;
      exp_out = {busy_at(t), idx2addr(m_idx)};
    end else if (busy_at(t)) begin
      exp_ign = 1'b1;
    end else if (r_s) begin
      if (r_w) begin
        has_out = 1'b1;
        exp_out = m_mem[m_idx];
      end else begin
        m_mem[m_idx] = d;
      end
      m_idx = m_inc ? (m_idx + 1) % 80 : (m_idx + 79) % 80;
      m_busy_end = t + CMD_CYCLES;
    end else begin
      hb = -1;
      for (int b = 7; b >= 0; b--) if (d[b] && hb < 0) hb = b;
      case (hb)
        7: begin
          a = d[6:0];
          if ((int'(a) % 64) < 40) begin
            m_idx = (int'(a) / 64) * 40 + int'(a) % 64;
            m_busy_end = t + CMD_CYCLES;
          end else exp_ign = 1'b1;
        end
        6: exp_ign = 1'b1;
        5, 4: m_busy_end = t + CMD_CYCLES;
        3: begin m_on = d[2]; m_cur = d[1]; m_busy_end = t + CMD_CYCLES; end
        2: begin m_inc = d[1]; m_busy_end = t + CMD_CYCLES; end
        1: begin m_idx = 0; m_busy_end = t + CMD_CYCLES; end
        0: begin
          m_idx = 0;
          m_inc = 1'b1;
          for (int i = 0; i < 80; i++) m_mem[i] = 8'h20;
          m_busy_end = t + CLEAR_LEN;
        end
        default: ;
      endcase
    end
    tick();
    check_eq("ignored", cmd_ignored, exp_ign);
    check_eq("ac", address_counter, idx2addr(m_idx));
    check_eq("on", on, m_on);
    check_eq("cursor", cursor_on, m_cur);
    check_eq("busy", busy, busy_at(cyc));
    check_eq("oe_post", lcd_data_oe, 1'b0);
    if (has_out) check_eq("read_out", lcd_data_out, exp_out);
  endtask

  task automatic scan_check(input logic [6:0] a);
    scan_addr = a;
    tick();
    check_eq("scan", scan_char, scan_model(a));
  endtask

  task automatic scan_all();
    for (int a = 0; a < 128; a++) scan_check(7'(a));
  endtask

  logic [7:0] old_char;
  logic [7:0] rnd;

  initial begin
    tick();
    do_reset();
    wait_idle();
    scan_check(7'h00);
    scan_check(7'h27);
    scan_check(7'h40);
    scan_check(7'h67);

    // Sequential fill of line 0 head.
    xfer(1'b0, 1'b0, 8'h80); wait_idle();
    for (int i = 0; i < 16; i++) begin
      xfer(1'b1, 1'b0, 8'h31); wait_idle();
    end
    for (int a = 0; a < 16; a++) scan_check(7'(a));

    // Line wrap in both directions.
    xfer(1'b0, 1'b0, 8'hA7); wait_idle();
    xfer(1'b1, 1'b0, 8'h41); wait_idle();
    xfer(1'b0, 1'b0, 8'hE7); wait_idle();
    xfer(1'b1, 1'b0, 8'h42); wait_idle();
    xfer(1'b0, 1'b0, 8'h04); wait_idle();
    xfer(1'b0, 1'b0, 8'h80); wait_idle();
    xfer(1'b1, 1'b0, 8'h43); wait_idle();
    xfer(1'b0, 1'b0, 8'hC0); wait_idle();
    xfer(1'b1, 1'b0, 8'h44); wait_idle();
    xfer(1'b0, 1'b0, 8'h06); wait_idle();

    // Back-to-back strobes: the second lands in busy and is dropped.
    xfer(1'b1, 1'b0, 8'h50);
    xfer(1'b1, 1'b0, 8'h51);
    wait_idle();
    xfer(1'b1, 1'b0, 8'h52);
    xfer(1'b0, 1'b1, 8'h00);
    wait_idle();

    // Invalid address, CGRAM, display control, no-op.
    xfer(1'b0, 1'b0, 8'hA8); wait_idle();
    xfer(1'b0, 1'b0, 8'h45); wait_idle();
    xfer(1'b0, 1'b0, 8'h0E); wait_idle();
    xfer(1'b0, 1'b0, 8'h00); wait_idle();
    xfer(1'b1, 1'b1, 8'h00); wait_idle();

    // Scan of the entry being written returns the old contents first.
    scan_addr = idx2addr(m_idx);
    old_char = m_mem[m_idx];
    xfer(1'b1, 1'b0, 8'h7A);
    check_eq("scan_rbw_old", scan_char, old_char);
    tick();
    check_eq("scan_rbw_new", scan_char, scan_model(scan_addr));
    wait_idle();

    // Randomized traffic with random spacing, including deliberate busy hits.
    for (int n = 0; n < 250; n++) begin
      int op;
      int g;
      op = $urandom_range(0, 9);
      case (op)
        0, 1, 2, 3: xfer(1'b1, 1'b0, 8'($urandom_range(8'h21, 8'h7E)));
        4: xfer(1'b1, 1'b1, 8'h00);
        5: xfer(1'b0, 1'b1, 8'h00);
        6: xfer(1'b0, 1'b0, 8'h80 | 8'($urandom_range(0, 127)));
        7: xfer(1'b0, 1'b0, 8'h04 | 8'($urandom_range(0, 3)));
        8: xfer(1'b0, 1'b0, 8'h08 | 8'($urandom_range(0, 7)));
        default: begin
          rnd = 8'($urandom_range(0, 15));
          case (rnd)
            8'd0:    xfer(1'b0, 1'b0, 8'h01);
            8'd1:    xfer(1'b0, 1'b0, 8'h00);
            8'd2:    xfer(1'b0, 1'b0, 8'h40 | 8'($urandom_range(0, 63)));
            8'd3:    xfer(1'b0, 1'b0, 8'h10 | 8'($urandom_range(0, 15)));
            8'd4:    xfer(1'b0, 1'b0, 8'h20 | 8'($urandom_range(0, 31)));
            default: xfer(1'b0, 1'b0, 8'h02 | 8'($urandom_range(0, 1)));
          endcase
        end
      endcase
      g = $urandom_range(0, 3);
      if (g == 0) wait_idle();
      else repeat (g - 1) tick();
    end
    wait_idle();
    scan_all();

    // Fill line 1, then clear.
    xfer(1'b0, 1'b0, 8'hC0); wait_idle();
    for (int i = 0; i < 40; i++) begin
      xfer(1'b1, 1'b0, 8'(8'h41 + 8'(i % 26))); wait_idle();
    end
    xfer(1'b0, 1'b0, 8'h01);
    wait_idle();
    scan_all();

    // Reset in the middle of a clear restarts the full reset clear.
    xfer(1'b0, 1'b0, 8'hC5); wait_idle();
    for (int i = 0; i < 10; i++) begin
      xfer(1'b1, 1'b0, 8'h5A); wait_idle();
    end
    xfer(1'b0, 1'b0, 8'h01);
    repeat (39) tick();
    do_reset();
    wait_idle();
    scan_all();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lcd_responder.md
# lcd_responder

Character-LCD responder: the display-side end of the HD44780-style parallel bus driven by the team's LCD controllers. It samples `enable`/`rs`/`rw`/`lcd_data_in` on the enable falling edge and decodes commands and data writes into an 80-byte DDRAM. It returns busy flag, address counter and DDRAM reads. A scan port exposes DDRAM contents to downstream consumers: a text renderer on the FPGA, or the bench scoreboard.

## Interface
- `CMD_CYCLES`, default 2: busy duration after a non-clear command or data write.
- `CLEAR_CYCLES`, default 96: minimum busy duration for clear display; effective duration is max(80, CLEAR_CYCLES).
- `clock  in  1  single system clock; all logic on its rising edge`
- `reset_n  in  1  asynchronous, active-low reset`
- `enable  in  1  bus strobe E, synchronous to clock; falling edge commits a transfer`
- `rs  in  1  0 = instruction/status, 1 = DDRAM data`
- `rw  in  1  0 = write, 1 = read`
- `lcd_data_in  in  8  write data/command`
- `lcd_data_out  out  8  read data, registered`
- `lcd_data_oe  out  1  high while enable=1 and rw=1`
- `busy  out  1  busy flag`
- `address_counter  out  7  current AC (DDRAM address form)`
- `on  out  1  display-on bit D`
- `cursor_on  out  1  cursor bit C`
- `scan_addr  in  7  DDRAM address to inspect`
- `scan_char  out  8  character at scan_addr, 1-cycle latency`
- `cmd_ignored  out  1  one-cycle pulse: strobe dropped (busy, unsupported, invalid address)`

## Operation
- Strobe = `enable_q`=1 and `enable`=0. `rs`, `rw` and `lcd_data_in` are sampled in that cycle.
- Valid addresses: 0x00–0x27 (line 0) and 0x40–0x67 (line 1). Index = addr[5:0] + (addr[6] ? 40 : 0).
- AC increment: 0x27→0x40, 0x67→0x00.
- AC decrement (I/D=0): 0x40→0x27, 0x00→0x67.
- State machine states:
  - RESET_CLEAR: entered from reset.
  - IDLE.
  - EXEC: counts down CMD_CYCLES.
  - CLEAR: writes 0x20 to index 0..79, one per cycle, and holds busy for at least CLEAR_CYCLES.
  - RESET_CLEAR and CLEAR both exit to IDLE.
- Write instruction (rs=0, rw=0), decoded by highest set bit:
  - 1aaaaaaa: AC ← a. An invalid a is ignored and pulses `cmd_ignored`.
  - 01xxxxxx: CGRAM address is unsupported; `cmd_ignored` pulses and no busy is raised.
  - 001xxxxx, 0001xxxx: accepted with no effect; → EXEC.
  - 00001DCB: `on` ← D, `cursor_on` ← C; → EXEC.
  - 000001IS: I/D ← I; S is ignored; → EXEC.
  - 0000001x: AC ← 0x00; → EXEC.
  - 00000001: AC ← 0x00, I/D ← 1; → CLEAR.
  - 00000000: no operation, no busy.
- Data write (rs=1, rw=0): DDRAM[AC] ← data, then AC steps by I/D; → EXEC.
- Status read (rs=0, rw=1): `lcd_data_out` = {busy, AC}. Allowed while busy; no state change.
- Data read (rs=1, rw=1): `lcd_data_out` = DDRAM[AC], then AC steps on the strobe; → EXEC.
- While busy, any strobe other than a status read is dropped and pulses `cmd_ignored`.
- Scan port: registered read. An invalid `scan_addr` returns 0x20. A same-cycle write to the same entry returns the old value.

## Timing
- Reset values: `lcd_data_out`=0x00, `lcd_data_oe`=0, `busy`=1, `address_counter`=0x00, `on`=0, `cursor_on`=0, `scan_char`=0x00, `cmd_ignored`=0, I/D=1, `enable_q`=0.
- After reset deassertion, busy stays high for max(80, CLEAR_CYCLES) cycles; DDRAM then reads all 0x20.
- Strobe at cycle t:
  - AC, `on` and DDRAM updates are visible at t+1.
  - `busy`=1 from t+1 to t+CMD_CYCLES, low at t+CMD_CYCLES+1.
  - `lcd_data_out` is valid from t+1 for reads. It is also refreshed every cycle while `enable`=1 and `rw`=1, so data is present before the falling edge.
- Clear: busy from t+1 for max(80, CLEAR_CYCLES) cycles.
- A controller strobing every 2 cycles with CMD_CYCLES=2 hits busy every other strobe. This is intended and exercises the drop path.
- Reset mid-CLEAR or mid-EXEC restarts RESET_CLEAR.

## Structure
- Package `lcd_pkg`:
  - instruction mask constants
  - `DDRAM_DEPTH`=80, `LCD_SPACE`=8'h20
  - state enum
  - address-to-index and AC step functions
- Sub-module `lcd_ddram`: 80×8 memory with one write/read port and one registered read-only scan port, read-before-write.
- Decode, FSM and AC live in `lcd_responder`.

## Test plan
- Reset, wait 96 cycles → `busy` falls; `scan_char` at 0x00, 0x27, 0x40 and 0x67 all read 0x20.
- Write 0x80 then data 0x31 ×16, spaced past busy → AC=0x10; DDRAM 0x00–0x0F = 0x31.
- AC=0x27, write 0x41 → AC=0x40. Entry mode 0x04, AC=0x00, write → AC=0x67.
- Data write immediately followed by a data strobe 2 cycles later → second strobe dropped, `cmd_ignored` pulses. A status read in between returns bit7=1 with AC.
- Command 0xA8 (invalid) → AC unchanged, `cmd_ignored`. 0x0E → `on`=1, `cursor_on`=1.
- Clear 0x01 after filling line 1 → busy for 96 cycles, all entries 0x20, AC=0. `reset_n` pulsed at cycle 40 of the clear → full RESET_CLEAR restart.
